// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for the dual-clock FIFO; runs entirely in the read
//   clock domain. Issues FIFO pops, absorbs the 1-cycle FIFO read latency
//   with a 2-entry skid buffer, and presents words on a valid/ready stream
//   grouped into PKT_LEN-word frames marked by m_last.
//
//   Ports
//     clk        in   read-domain clock (FIFO r_clk)
//     rst        in   asynchronous active-low reset
//     enable     in   allow new FIFO reads
//     fifo_data  in   FIFO read data, valid the cycle after fifo_r_en
//     fifo_empty in   FIFO empty flag
//     fifo_r_en  out  FIFO read enable / pop
//     m_data     out  stream data (skid buffer head)
//     m_valid    out  stream valid
//     m_ready    in   stream ready
//     m_last     out  last word of frame
//     busy       out  words buffered or a read in flight
//     word_cnt   out  accepted words     (FIFO_STREAM_READER_STATS_EN only)
//     frame_cnt  out  accepted frames    (FIFO_STREAM_READER_STATS_EN only)
//
//   Optional build macro: FIFO_STREAM_READER_STATS_EN adds the statistics
//   counters and their output ports.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [15:0]           frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic                  pop;
    logic [1:0]            level;
    logic [1:0]            occ_after_pop;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign pop     = m_valid & m_ready;
    assign m_last  = m_valid & (idx_q == LAST_IDX);
    assign busy    = (occ_q != 2'd0) | inflight_q;

    // occ + inflight never exceeds 2, and pop implies occ >= 1, so this
    // 2-bit sum neither overflows nor underflows.
    assign level         = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign occ_after_pop = occ_q - {1'b0, pop};

    // Gated by rst so no pop reaches the FIFO while reset is held.
    assign fifo_r_en = rst & enable & ~fifo_empty & (level < 2'd2);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        idx_d  = idx_q;
        occ_d  = level;
        // Pop shifts the tail forward; the capture below lands in the first
        // free slot after that shift, so capture-with-pop needs no special case.
        if (pop) begin
            head_d = tail_q;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            idx_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_r_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            idx_q      <= idx_d;
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] word_cnt_q;
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (m_last) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule
